// File: rtl/video_mode_detect_if.sv
// Sync inputs and classification outputs of video_mode_detect.
// The master modport is the video source side; the slave modport is the detector.
interface video_mode_detect_if #(
   parameter int CNT_W  = 22,
   parameter int LINE_W = 11
);
   logic              i_hsync;
   logic              i_vsync;
   logic              o_valid;
   logic              o_passthrough;
   logic              o_60hz;
   logic              o_change;
   logic [LINE_W-1:0] o_lines;
   logic [CNT_W-1:0]  o_period;

   modport master (
      output i_hsync, i_vsync,
      input  o_valid, o_passthrough, o_60hz, o_change, o_lines, o_period
   );

   modport slave (
      input  i_hsync, i_vsync,
      output o_valid, o_passthrough, o_60hz, o_change, o_lines, o_period
   );
endinterface

// File: rtl/video_mode_detect.sv
// Input-video classifier: lines/frame and frame period -> passthrough/upscale and 50/60 Hz,
// debounced over STABLE_FRAMES frames. Optional loss-of-signal timeout under `VMD_TIMEOUT_EN.
module video_mode_detect #(
   parameter int CNT_W         = 22,
   parameter int LINE_W        = 11,
   parameter int LINE_THRESH   = 700,
   parameter int PERIOD_THRESH = 1_400_943,
   parameter int MIN_PERIOD    = 100_000,
   parameter int STABLE_FRAMES = 3,
   parameter int TIMEOUT       = 4_000_000
) (
   input logic               clk,
   input logic               reset,
   video_mode_detect_if.slave vid
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACQUIRE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam int STAB_W = $clog2(STABLE_FRAMES + 1);

   localparam logic [CNT_W-1:0]  PERIOD_MAX = '1;
   localparam logic [CNT_W-1:0]  PERIOD_ONE = 1;
   localparam logic [CNT_W-1:0]  MIN_P      = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0]  P_THR      = CNT_W'(PERIOD_THRESH);
   localparam logic [LINE_W-1:0] LINE_MAX   = '1;
   localparam logic [LINE_W-1:0] LINE_ONE   = 1;
   localparam logic [LINE_W-1:0] L_THR      = LINE_W'(LINE_THRESH);
   localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(STABLE_FRAMES);
   localparam logic [STAB_W-1:0] STAB_ONE   = 1;

   function automatic logic [CNT_W-1:0] period_sat_inc(input logic [CNT_W-1:0] v);
      return (v == PERIOD_MAX) ? v : v + PERIOD_ONE;
   endfunction

   function automatic logic [LINE_W-1:0] line_sat_inc(input logic [LINE_W-1:0] v);
      return (v == LINE_MAX) ? v : v + LINE_ONE;
   endfunction

   function automatic logic [STAB_W-1:0] stable_sat_inc(input logic [STAB_W-1:0] v);
      return (v >= STAB_MAX) ? STAB_MAX : v + STAB_ONE;
   endfunction

   logic [2:0]        hsync_s;
   logic [2:0]        vsync_s;
   logic [CNT_W-1:0]  period_cnt;
   logic [LINE_W-1:0] line_cnt;
   logic [1:0]        state;
   logic [1:0]        pending;
   logic [STAB_W-1:0] stable;
   logic              valid_r;
   logic              pass_r;
   logic              hz60_r;
   logic              change_r;
   logic [LINE_W-1:0] lines_r;
   logic [CNT_W-1:0]  period_r;

   logic              boundary;
   logic              line_edge;
   logic              accept;
   logic [1:0]        cand;
   logic [1:0]        pending_nxt;
   logic [STAB_W-1:0] stable_nxt;
   logic              commit_first;
   logic              commit_new;
   logic              timeout;

   // Synchroniser outputs -> edge detection (s2 is the older sample)
   assign boundary  = vsync_s[2] & ~vsync_s[1];
   assign line_edge = ~hsync_s[2] & hsync_s[1];
   assign accept    = boundary && (period_cnt >= MIN_P);

   // A saturated period is treated as "too long" and therefore 50 Hz
   assign cand = {line_cnt > L_THR, (period_cnt != PERIOD_MAX) && (period_cnt < P_THR)};

   always_comb begin
      pending_nxt = pending;
      stable_nxt  = stable;
      if (cand == pending) begin
         stable_nxt = stable_sat_inc(stable);
      end else begin
         pending_nxt = cand;
         stable_nxt  = STAB_ONE;
      end
   end

   assign commit_first = (state == ACQUIRE) && (stable_nxt == STAB_MAX);
   assign commit_new   = (state == LOCKED) && (stable_nxt == STAB_MAX) &&
                         (pending_nxt != {pass_r, hz60_r});

`ifdef VMD_TIMEOUT_EN
   assign timeout = (state != IDLE) && (period_cnt == CNT_W'(TIMEOUT));
`else
   assign timeout = 1'b0;
`endif

   // Synchronisers and frame measurement counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_s    <= '0;
         vsync_s    <= '0;
         period_cnt <= '0;
         line_cnt   <= '0;
      end else begin
         hsync_s <= {hsync_s[1:0], vid.i_hsync};
         vsync_s <= {vsync_s[1:0], vid.i_vsync};
         if (accept) begin
            period_cnt <= PERIOD_ONE;
            line_cnt   <= line_edge ? LINE_ONE : '0;
         end else begin
            period_cnt <= period_sat_inc(period_cnt);
            if (line_edge)
               line_cnt <= line_sat_inc(line_cnt);
         end
      end
   end

   // Classification state machine and committed outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pending  <= '0;
         stable   <= '0;
         valid_r  <= 1'b0;
         pass_r   <= 1'b0;
         hz60_r   <= 1'b0;
         change_r <= 1'b0;
         lines_r  <= '0;
         period_r <= '0;
      end else begin
         change_r <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: state <= ACQUIRE;
               ACQUIRE, LOCKED: begin
                  pending  <= pending_nxt;
                  stable   <= stable_nxt;
                  lines_r  <= line_cnt;
                  period_r <= period_cnt;
                  if (commit_first || commit_new) begin
                     {pass_r, hz60_r} <= pending_nxt;
                     change_r         <= 1'b1;
                  end
                  if (commit_first) begin
                     valid_r <= 1'b1;
                     state   <= LOCKED;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (timeout) begin
            state   <= IDLE;
            valid_r <= 1'b0;
            stable  <= '0;
         end
      end
   end

   assign vid.o_valid       = valid_r;
   assign vid.o_passthrough = pass_r;
   assign vid.o_60hz        = hz60_r;
   assign vid.o_change      = change_r;
   assign vid.o_lines       = lines_r;
   assign vid.o_period      = period_r;
endmodule

// File: doc/video_mode_detect.md
# video_mode_detect

Parametrised input-video classifier feeding the PAL/VGA-to-HD conversion path. It measures lines per frame and frame period from the incoming sync pulses, classifies the source as passthrough (VGA-class) or upscale, and as 50 Hz or 60 Hz. Classification is debounced over consecutive frames and reported with a valid flag and a change strobe. It is the generalised successor to the ad-hoc line counter and 50/60 Hz threshold logic in the conversion top level.

## Interface
Parameters:
- `CNT_W`, 22: frame-period counter width in clk cycles.
- `LINE_W`, 11: line counter width.
- `LINE_THRESH`, 700: lines strictly above this → passthrough.
- `PERIOD_THRESH`, 1_400_943: period strictly below this → 60 Hz class (53 Hz at 74.25 MHz).
- `MIN_PERIOD`, 100_000: boundaries closer than this are glitches.
- `STABLE_FRAMES`, 3: consecutive identical classifications required to commit.
- `TIMEOUT`, 4_000_000: cycles without a boundary before declaring loss (needs `VMD_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock; all logic is in this domain.
- `reset`  in  1  asynchronous, active-high.
- `i_hsync`  in  1  asynchronous horizontal sync, active-high.
- `i_vsync`  in  1  asynchronous vertical sync, active-high.
- `o_valid`  out  1  classification committed and signal present.
- `o_passthrough`  out  1  committed line class.
- `o_60hz`  out  1  committed rate class; 0 = 50 Hz.
- `o_change`  out  1  one-cycle pulse when a committed class is written.
- `o_lines`  out  LINE_W  last accepted frame's line count.
- `o_period`  out  CNT_W  last accepted frame's period in clk cycles.

## Operation
- Each sync input uses a 3-stage synchroniser (s0, s1, s2).
- A frame boundary is s2=1 and s1=0 (vsync falling edge), subject to the glitch rule below.
- A line edge is the hsync rising edge, s2=0 and s1=1.
- Period counter:
  - Loads 1 at each accepted boundary and increments each cycle.
  - Saturates at 2^CNT_W−1.
  - At a boundary it holds exactly the clk cycles since the previous accepted boundary.
- Line counter:
  - Counts line edges and saturates at 2^LINE_W−1.
  - Loads 0 at a boundary, or 1 if a line edge coincides with it (that edge belongs to the new frame).
- Glitch rule: a boundary with period < MIN_PERIOD is ignored entirely. No counter resets and no classification happen.
- Candidate class at each accepted boundary is {lines > LINE_THRESH, period < PERIOD_THRESH}.
- Pending class register and stable counter (saturating at STABLE_FRAMES):
  - Candidate equals pending: stable counter +1.
  - Otherwise: pending ← candidate and stable counter ← 1.
- State machine:
  - IDLE: entered from reset or timeout. The first accepted boundary only restarts the counters, because the partial frame is discarded. Then go to ACQUIRE. o_valid=0.
  - ACQUIRE: update o_lines/o_period at every accepted boundary. When the stable counter reaches STABLE_FRAMES, commit the class, pulse o_change, set o_valid=1 and go to LOCKED.
  - LOCKED: o_lines/o_period update every frame. If pending ≠ committed and the stable counter reaches STABLE_FRAMES, commit the new class and pulse o_change. o_valid stays 1.
- Commit writes o_passthrough and o_60hz together. o_change does not pulse for a re-commit of the same class.

## Timing
- Reset values:
  - o_valid, o_passthrough, o_60hz, o_change, o_lines, o_period all 0.
  - State IDLE; sync stages cleared to 0; counters 0.
- Latency: i_vsync falls before clk edge k → o_lines/o_period/commit registered at edge k+2 (s1 at k+1, detection in the following cycle).
- o_change is high for exactly the one cycle after the commit edge.
- Reset mid-frame forces IDLE immediately (asynchronous). Re-lock needs 1 + STABLE_FRAMES boundaries.
- Saturated period at a boundary counts as ≥ PERIOD_THRESH → 50 Hz class.

## Configuration
- `VMD_TIMEOUT_EN` defined:
  - When the period counter reaches TIMEOUT in ACQUIRE or LOCKED, go to IDLE and clear o_valid and the stable counter in that cycle.
  - o_passthrough, o_60hz, o_lines and o_period hold their last values. No o_change pulse.
- Undefined:
  - No timeout logic. Loss of vsync leaves the state and all outputs held indefinitely.
  - The period counter still saturates.

## Test plan
Sim parameters: CNT_W=12, LINE_W=10, LINE_THRESH=20, PERIOD_THRESH=1000, MIN_PERIOD=100, STABLE_FRAMES=3, TIMEOUT=3000.
- Reset, then 4 frames of period 1200 with 10 lines → o_valid rises at the 4th boundary+2 edges. Expect o_passthrough=0, o_60hz=0, o_lines=10, o_period=1200, and one o_change pulse.
- Locked at 1200/10, then switch to period 900 with 30 lines:
  - After the 2nd such frame: class unchanged and no pulse.
  - After the 3rd: o_60hz=1, o_passthrough=1, single o_change pulse.
- Alternate frames of 900 and 1200 while locked → stable counter never reaches 3. Class unchanged, no o_change, o_period tracks each frame.
- Inject a vsync pulse 50 cycles after a boundary → ignored. Next boundary reports period 1200 and the line count continues uninterrupted.
- Line edge coincident with a boundary → new frame's o_lines is 1 greater than without the coincident edge.
- With `VMD_TIMEOUT_EN`, stop vsync while locked → o_valid falls 3000 cycles after the last boundary and class outputs hold. Without it, o_valid stays 1.
